// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN layer sequencer.
package cnn_pkg;

  localparam int unsigned NUM_STAGES_DFLT = 3;

  // Engine order within a run.
  localparam int unsigned STG_CONV  = 0;
  localparam int unsigned STG_POOL  = 1;
  localparam int unsigned STG_DENSE = 2;

  typedef logic [$clog2(NUM_STAGES_DFLT)-1:0] stage_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    GAP,
    FINISH,
    ERROR
  } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Per-stage watchdog: loadable down-counter that flags the last allowed WAIT cycle.
module seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES);
  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt_q;

  // Count remaining WAIT cycles; holds at zero rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // A count of one during WAIT means this is the final permitted cycle.
  assign expire = ENABLED && en && (cnt_q == CW'(1));

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Layer scheduler: launches engines in order, owns the shared-buffer select,
// watches each stage for a hang and records the length of the last good run.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  output logic [NUM_STAGES-1:0]         stage_start,
  input  logic [NUM_STAGES-1:0]         stage_done,
  output logic [$clog2(NUM_STAGES)-1:0] owner_sel,
  output logic                          owner_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [$clog2(NUM_STAGES)-1:0] err_stage,
  output logic [CNT_W-1:0]              total_cycles
);

  localparam int unsigned IW = $clog2(NUM_STAGES);

  seq_state_t     state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d, total_d;
  logic           wd_expire;
  logic           in_busy;

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (abort),
    .load  (state_q == LAUNCH),
    .en    (state_q == WAIT),
    .expire(wd_expire)
  );

  assign in_busy = (state_q inside {LAUNCH, WAIT, GAP, FINISH});

  // Next state, stage index and saturating run counter.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    run_cnt_d = run_cnt_q;
    if (in_busy && !(&run_cnt_q)) begin
      run_cnt_d = run_cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LAUNCH;
          idx_d     = '0;
          run_cnt_d = '0;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        // Done on the final watchdog cycle still counts as success.
        if (stage_done[idx_q]) begin
          state_d = (idx_q == IW'(NUM_STAGES - 1)) ? FINISH : GAP;
        end else if (wd_expire) begin
          state_d = ERROR;
        end
      end
      GAP: begin
        idx_d   = idx_q + IW'(1);
        state_d = LAUNCH;
      end
      FINISH:  state_d = IDLE;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
    // Run length includes the FINISH cycle itself.
    total_d = (&run_cnt_d) ? run_cnt_d : run_cnt_d + CNT_W'(1);
  end

  // State, index and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_start  <= '0;
      owner_valid  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_stage    <= '0;
      total_cycles <= '0;
    end else begin
      stage_start <= (state_d == LAUNCH) ? (NUM_STAGES'(1) << idx_d) : '0;
      owner_valid <= (state_d inside {LAUNCH, WAIT});
      busy        <= (state_d inside {LAUNCH, WAIT, GAP, FINISH});
      done        <= (state_d == FINISH);
      error       <= (state_d == ERROR);
      if ((state_d == ERROR) && (state_q != ERROR)) begin
        err_stage <= idx_q;
      end
      if (state_d == FINISH) begin
        total_cycles <= total_d;
      end
    end
  end

  assign owner_sel = idx_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer with stub engines of programmable latency.
module tb_cnn_layer_sequencer;
  import cnn_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  stage_start;
  logic [2:0]  stage_done;
  logic [1:0]  owner_sel;
  logic        owner_valid;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_stage;
  logic [31:0] total_cycles;

  int checks = 0;
  int failures = 0;

  // Stub engines: done pulses dly[i] cycles after the stage_start cycle; 0 = never.
  int unsigned dly [3] = '{10, 20, 5};
  int unsigned rem [3] = '{0, 0, 0};
  logic [2:0]  stub_done = '0;
  logic [2:0]  noise = '0;

  // Scoreboard queues filled by the stimulus, drained by the monitor.
  logic [2:0]  exp_start_q[$];
  int unsigned exp_total_q[$];
  stage_idx_t  exp_err_q[$];

  int   busy_cnt = 0;
  int   gap_len = 0;
  logic err_prev = 1'b0;

  assign stage_done = stub_done | noise;

  always #5 clk = ~clk;

  cnn_layer_sequencer #(
    .NUM_STAGES    (3),
    .TIMEOUT_CYCLES(64),
    .CNT_W         (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .stage_start (stage_start),
    .stage_done  (stage_done),
    .owner_sel   (owner_sel),
    .owner_valid (owner_valid),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_stage   (err_stage),
    .total_cycles(total_cycles)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (stage_start[i]) begin
        rem[i]       <= (dly[i] == 0) ? 0 : dly[i] - 1;
        stub_done[i] <= (dly[i] == 1);
      end else if (rem[i] != 0) begin
        rem[i]       <= rem[i] - 1;
        stub_done[i] <= (rem[i] == 1);
      end else begin
        stub_done[i] <= 1'b0;
      end
    end
  end

  // Monitor: compares DUT events against the scoreboard on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      gap_len  = 0;
      err_prev = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      else busy_cnt = 0;
      if (stage_start != 3'b000) begin
        if (exp_start_q.size() == 0) chk("unexpected_stage_start", stage_start, 0);
        else chk("stage_start_order", stage_start, exp_start_q.pop_front());
      end
      if (!busy) begin
        gap_len = 0;
      end else if (!owner_valid && !done) begin
        gap_len++;
      end else if (owner_valid && gap_len != 0) begin
        chk("owner_gap_len", gap_len, 1);
        gap_len = 0;
      end
      if (done) begin
        if (exp_total_q.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          int unsigned e;
          e = exp_total_q.pop_front();
          chk("total_cycles", total_cycles, e);
          chk("busy_len", busy_cnt, e);
        end
      end
      if (error && !err_prev) begin
        if (exp_err_q.size() == 0) chk("unexpected_error", error, 0);
        else chk("err_stage", err_stage, exp_err_q.pop_front());
      end
      err_prev = error;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
  endtask

  task automatic push_run(input int unsigned total);
    exp_start_q.push_back(3'b001);
    exp_start_q.push_back(3'b010);
    exp_start_q.push_back(3'b100);
    exp_total_q.push_back(total);
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_error(input int max, input string tag);
    int n = 0;
    while (!error && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, error, 1);
  endtask

  task automatic wait_start(input logic [2:0] mask, input int max, input string tag);
    int n = 0;
    while (stage_start != mask && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, stage_start, mask);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stage_start"}, stage_start, 0);
    chk({tag, "_owner_sel"}, owner_sel, 0);
    chk({tag, "_owner_valid"}, owner_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_err_stage"}, err_stage, 0);
    chk({tag, "_total_cycles"}, total_cycles, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // 1: normal run, 11 + 1 + 21 + 1 + 6 + 1 = 41 cycles.
    dly = '{10, 20, 5};
    push_run(41);
    pulse_start();
    chk("start_latency", stage_start, 3'b001);
    wait_idle(200, "s1_idle");
    chk("s1_total", total_cycles, 41);
    chk("s1_no_error", error, 0);

    // 2: stage 1 hangs, start in ERROR ignored, abort recovers.
    dly = '{10, 0, 5};
    exp_start_q.push_back(3'b001);
    exp_start_q.push_back(3'b010);
    exp_err_q.push_back(stage_idx_t'(STG_POOL));
    pulse_start();
    wait_error(200, "s2_error");
    chk("s2_err_stage", err_stage, STG_POOL);
    chk("s2_busy", busy, 0);
    chk("s2_owner_valid", owner_valid, 0);
    repeat (10) @(negedge clk);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("s2_error_sticky", error, 1);
    chk("s2_busy_after_start", busy, 0);
    pulse_abort();
    chk("s2_abort_clears", error, 0);
    dly = '{10, 20, 5};
    push_run(41);
    pulse_start();
    wait_idle(200, "s2_rerun_idle");

    // 3: done on the 64th WAIT cycle succeeds (65+1+21+1+6+1 = 95); 65th fails.
    dly = '{64, 20, 5};
    push_run(95);
    pulse_start();
    wait_idle(300, "s3a_idle");
    chk("s3a_no_error", error, 0);
    dly = '{65, 20, 5};
    exp_start_q.push_back(3'b001);
    exp_err_q.push_back(stage_idx_t'(STG_CONV));
    pulse_start();
    wait_error(300, "s3b_error");
    chk("s3b_err_stage", err_stage, STG_CONV);
    pulse_abort();
    chk("s3b_abort_clears", error, 0);
    chk("s3b_total_kept", total_cycles, 95);

    // 4: re-start and foreign done during stage 0 are ignored.
    dly = '{10, 20, 5};
    push_run(41);
    pulse_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    noise = 3'b100;
    @(negedge clk);
    start = 1'b0;
    noise = 3'b000;
    wait_idle(200, "s4_idle");
    chk("s4_total", total_cycles, 41);

    // 5: asynchronous reset in the middle of stage 1.
    exp_start_q.push_back(3'b001);
    exp_start_q.push_back(3'b010);
    pulse_start();
    wait_start(3'b010, 100, "s5_stage1");
    repeat (5) @(negedge clk);
    chk("s5_busy_before_reset", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("s5_async");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    push_run(41);
    pulse_start();
    wait_idle(200, "s5_rerun_idle");
    chk("s5_total", total_cycles, 41);

    // 6: abort with start during stage 2.
    exp_start_q.push_back(3'b001);
    exp_start_q.push_back(3'b010);
    exp_start_q.push_back(3'b100);
    pulse_start();
    wait_start(3'b100, 200, "s6_stage2");
    repeat (2) @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("s6_busy", busy, 0);
    chk("s6_owner_valid", owner_valid, 0);
    chk("s6_done", done, 0);
    chk("s6_total_kept", total_cycles, 41);
    repeat (10) @(negedge clk);
    chk("s6_stays_idle", busy, 0);

    chk("left_exp_start", exp_start_q.size(), 0);
    chk("left_exp_done", exp_total_q.size(), 0);
    chk("left_exp_err", exp_err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
